pipe_fetch_decode: RTL and testbench
====================================

// Module: pipe_fetch_decode
// PURPOSE
//  Stage 0 of the 4-stage ALU/memory pipeline: instruction fetch and decode.
//  - Holds a small instruction memory and a PC; issues one decoded instruction
//    (rs1, rs2, rd, func, addr) per cycle into the operand-fetch stage.
//  - Inserts bubbles on RAW hazards against destinations still in flight,
//    since regbank writeback lands two stages later.
//  - Stops on a HALT instruction.
// PARAMETERS
//  IMEM_AW    5   instruction memory address width (2**IMEM_AW words)
//  INSTR_W    24  instruction word width (fixed; field map below)
//  HAZ_DEPTH  2   number of previously issued rd values checked for RAW hazards
// PORTS
//  clk1        in   1        pipeline clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        1-cycle pulse: begin execution at PC=0
//  prog_we     in   1        instruction memory write enable
//  prog_addr   in   IMEM_AW  instruction memory write address
//  prog_data   in   INSTR_W  instruction memory write data
//  ds_ready    in   1        downstream pipeline may advance this cycle
//  rs1         out  4        source register 1
//  rs2         out  4        source register 2
//  rd          out  4        destination register
//  func        out  2        ALU function (0 add, 1 sub, 2 and, 3 xor)
//  addr        out  8        data memory address
//  out_valid   out  1        outputs carry a real instruction (0 = bubble)
//  busy        out  1        state is RUN
//  halted      out  1        HALT retired; sticky until start or reset
//  bad_op      out  1        sticky: reserved opcode fetched
//  issue_cnt   out  16       count of issued instructions, saturates at FFFF
//  bubble_cnt  out  16       count of hazard bubbles, saturates at FFFF
// BEHAVIOUR
//  - Instruction word fields:
//      [23:22] op (00 ALU, 01 NOP, 10 HALT, 11 reserved)
//      [21:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
//  - Reset (async, rst_n=0):
//      * All outputs, PC, counters and flags go to 0. State goes to IDLE.
//      * The scoreboard is cleared.
//      * Instruction memory contents are not reset.
//      * Reset asserted mid-RUN aborts immediately. The in-flight instruction is dropped.
//  - Instruction memory: combinational read at PC.
//      * prog_we is honoured only in IDLE or HALTED; it is ignored in RUN.
//  - State machine: IDLE, RUN, HALTED.
//      * IDLE --start--> RUN. HALTED --start--> RUN.
//      * On entry to RUN: PC=0, halted=0, scoreboard cleared.
//      * RUN --HALT issued--> HALTED.
//      * start while in RUN is ignored.
//  - Issue rule, evaluated each RUN cycle:
//      * When ds_ready=0, hold all outputs, PC and scoreboard. No counters change.
//      * hazard = (op==ALU) and (rs1 or rs2) equals a valid scoreboard rd.
//      * If hazard: out_valid<=0, PC holds, bubble_cnt++.
//      * Else, ALU: outputs<=fields, out_valid<=1, PC++, issue_cnt++.
//      * Else, NOP or reserved: out_valid<=0, PC++. Reserved also sets bad_op.
//      * Else, HALT: out_valid<=0, PC holds, go to HALTED.
//  - Scoreboard: HAZ_DEPTH-entry shift register of {valid, rd}.
//      * Shifts only when ds_ready=1.
//      * Shift-in value: {1, rd} on an ALU issue; {0, x} otherwise.
//      * Net effect: back-to-back dependency costs 2 bubbles; gap of 1 costs 1 bubble.
//  - Latency: start sampled at edge E0; the first instruction is valid after edge E1.
//  - PC wraps from 2**IMEM_AW-1 to 0 without a flag.
//  - Output fields keep their last value when out_valid=0.
//    Downstream must qualify with out_valid. NOP/bubble encodes as func=0, rd=0 at the consumer.
// STRUCTURE
//  - Shared package pipe_pkg:
//      * Opcode constants OP_ALU, OP_NOP, OP_HALT, OP_RSV.
//      * Func constants F_ADD, F_SUB, F_AND, F_XOR.
//      * Instruction field bit positions.
//      * State encodings S_IDLE, S_RUN, S_HALTED.
//  - One sub-module: pipe_hazard_sb.
//      * Contains the scoreboard shift register and comparators.
//      * Inputs: shift, issue, rd, rs1, rs2. Output: hazard.
// TESTING
//  1. Program {ALU add rd1 rs5 rs3; ALU sub rd2 rs6 rs4; HALT}, pulse start, ds_ready=1.
//     -> Two consecutive valid issues (1,5,3,f0) then (2,6,4,f1).
//     -> halted=1 on the 3rd cycle after start; issue_cnt=2.
//  2. Program {ALU rd1 rs5 rs3; ALU rd2 rs1 rs4; HALT}.
//     -> Issue, 2 bubbles (out_valid=0), then issue of rd2; bubble_cnt=2.
//  3. Program {ALU rd1; ALU rd7 rs8 rs9; ALU rd3 rs1 rs2}.
//     -> Exactly 1 bubble before the 3rd instruction.
//  4. Drop ds_ready for 3 cycles mid-program.
//     -> Outputs, PC and counters frozen; the sequence resumes unchanged.
//  5. Assert rst_n=0 mid-RUN.
//     -> Outputs 0 at once and state IDLE.
//     -> Re-run via start reproduces scenario 1 with the same instruction memory.
//  6. Fill all 32 words with ALU rd0 rs15 rs15 and no HALT.
//     -> PC wraps to 0 and issue continues without bubbles.
//     -> prog_we during RUN does not alter memory.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the ALU/memory pipeline.
// Holds the opcode, function and FSM state encodings, the 24-bit instruction
// field map, the scoreboard entry type and small helper functions.
package pipe_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_NOP  = 2'b01,
    OP_HALT = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    F_ADD = 2'b00,
    F_SUB = 2'b01,
    F_AND = 2'b10,
    F_XOR = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  // Instruction field LSB positions
  localparam int unsigned OP_LSB   = 22;
  localparam int unsigned FUNC_LSB = 20;
  localparam int unsigned RD_LSB   = 16;
  localparam int unsigned RS1_LSB  = 12;
  localparam int unsigned RS2_LSB  = 8;
  localparam int unsigned ADDR_LSB = 0;

  typedef struct packed {
    op_e         op;
    func_e       func;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  addr;
  } instr_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] rd;
  } sb_ent_t;

  function automatic instr_t decode(input logic [23:0] w);
    instr_t d;
    d.op   = op_e'(w[OP_LSB +: 2]);
    d.func = func_e'(w[FUNC_LSB +: 2]);
    d.rd   = w[RD_LSB +: 4];
    d.rs1  = w[RS1_LSB +: 4];
    d.rs2  = w[RS2_LSB +: 4];
    d.addr = w[ADDR_LSB +: 8];
    return d;
  endfunction

  // Saturating 16-bit increment
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_sb.sv
// RAW hazard scoreboard: a DEPTH-entry shift register of {valid, rd} for
// recently issued destinations, compared against the current sources.
// Ports:
//   clk1, rst_n  clock, async active-low reset
//   clr          drop all entries (start of a new run)
//   shift        advance the shift register (pipeline advancing)
//   issue        shift in a valid entry for rd (else an invalid entry)
//   rd           destination of the instruction being issued
//   chk          qualify the comparison (instruction reads registers)
//   rs1, rs2     sources of the current instruction
//   hazard       a source matches a valid in-flight destination
module pipe_hazard_sb
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift,
  input  logic       issue,
  input  logic [3:0] rd,
  input  logic       chk,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  output logic       hazard
);

  sb_ent_t sb_q [DEPTH];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i].vld <= 1'b0;
    end else if (shift) begin
      sb_q[0] <= '{vld: issue, rd: rd};
      for (int unsigned i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (chk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sb_q[i].vld && (sb_q[i].rd == rs1 || sb_q[i].rd == rs2)) hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_fetch_decode.sv
// Pipeline stage 0: instruction fetch and decode.
// Fetches from a small instruction memory at PC, issues one decoded ALU
// instruction per cycle, inserts bubbles on RAW hazards and stops on HALT.
// Ports:
//   clk1, rst_n              clock, async active-low reset
//   start                    pulse: begin execution at PC=0 (IDLE/HALTED)
//   prog_we/addr/data        instruction memory write port (not in RUN)
//   ds_ready                 downstream may advance; 0 freezes the stage
//   rs1, rs2, rd, func, addr decoded fields of the issued instruction
//   out_valid                fields carry a real instruction
//   busy, halted, bad_op     status flags
//   issue_cnt, bubble_cnt    saturating counters
module pipe_fetch_decode
  import pipe_pkg::*;
#(
  parameter int unsigned IMEM_AW   = 5,
  parameter int unsigned INSTR_W   = 24,
  parameter int unsigned HAZ_DEPTH = 2
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               ds_ready,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [3:0]         rd,
  output logic [1:0]         func,
  output logic [7:0]         addr,
  output logic               out_valid,
  output logic               busy,
  output logic               halted,
  output logic               bad_op,
  output logic [15:0]        issue_cnt,
  output logic [15:0]        bubble_cnt
);

  state_e             state_q;
  logic [IMEM_AW-1:0] pc_q;
  logic [INSTR_W-1:0] imem_q [2**IMEM_AW];
  logic [3:0]         rs1_q, rs2_q, rd_q;
  logic [1:0]         func_q;
  logic [7:0]         addr_q;
  logic               out_valid_q, busy_q, halted_q, bad_op_q;
  logic [15:0]        issue_cnt_q, bubble_cnt_q;

  instr_t cur;
  logic   is_alu, hazard, run_adv, sb_clr;

  // Instruction memory has no reset and is writable only outside RUN
  always_ff @(posedge clk1) begin
    if (prog_we && state_q != S_RUN) imem_q[prog_addr] <= prog_data;
  end

  assign cur     = decode(imem_q[pc_q]);
  assign is_alu  = (cur.op == OP_ALU);
  assign run_adv = (state_q == S_RUN) && ds_ready;
  assign sb_clr  = start && (state_q != S_RUN);

  pipe_hazard_sb #(
    .DEPTH(HAZ_DEPTH)
  ) u_sb (
    .clk1  (clk1),
    .rst_n (rst_n),
    .clr   (sb_clr),
    .shift (run_adv),
    .issue (is_alu && !hazard),
    .rd    (cur.rd),
    .chk   (is_alu),
    .rs1   (cur.rs1),
    .rs2   (cur.rs2),
    .hazard(hazard)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      func_q       <= '0;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      bad_op_q     <= 1'b0;
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state_q     <= S_RUN;
            pc_q        <= '0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          // ds_ready low freezes everything, including the scoreboard
          if (ds_ready) begin
            if (hazard) begin
              out_valid_q  <= 1'b0;
              bubble_cnt_q <= sat_inc(bubble_cnt_q);
            end else begin
              unique case (cur.op)
                OP_ALU: begin
                  rs1_q       <= cur.rs1;
                  rs2_q       <= cur.rs2;
                  rd_q        <= cur.rd;
                  func_q      <= cur.func;
                  addr_q      <= cur.addr;
                  out_valid_q <= 1'b1;
                  pc_q        <= pc_q + 1'b1;
                  issue_cnt_q <= sat_inc(issue_cnt_q);
                end
                OP_NOP: begin
                  out_valid_q <= 1'b0;
                  pc_q        <= pc_q + 1'b1;
                end
                OP_RSV: begin
                  out_valid_q <= 1'b0;
                  pc_q        <= pc_q + 1'b1;
                  bad_op_q    <= 1'b1;
                end
                OP_HALT: begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_HALTED;
                  busy_q      <= 1'b0;
                  halted_q    <= 1'b1;
                end
              endcase
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign func       = func_q;
  assign addr       = addr_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign bad_op     = bad_op_q;
  assign issue_cnt  = issue_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_fetch_decode.sv
// Scoreboard bench for pipe_fetch_decode: expected issue records are queued
// as programs are loaded and popped by a monitor whenever a new instruction
// leaves the stage; timing, counters and flags are checked at fixed points.
module tb_pipe_fetch_decode;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [23:0] prog_data = '0;
  logic        ds_ready = 1'b1;
  logic [3:0]  rs1, rs2, rd;
  logic [1:0]  func;
  logic [7:0]  addr;
  logic        out_valid, busy, halted, bad_op;
  logic [15:0] issue_cnt, bubble_cnt;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rdy_prev = 1'b0;
  logic [21:0] exp_q [$];
  int          pop_cyc [$];

  localparam logic [23:0] W_HALT = 24'h800000;
  localparam logic [23:0] W_RSV  = 24'hC00000;

  pipe_fetch_decode #(
    .IMEM_AW  (5),
    .INSTR_W  (24),
    .HAZ_DEPTH(2)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ds_ready  (ds_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .func      (func),
    .addr      (addr),
    .out_valid (out_valid),
    .busy      (busy),
    .halted    (halted),
    .bad_op    (bad_op),
    .issue_cnt (issue_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    cyc      <= cyc + 1;
    rdy_prev <= ds_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A new instruction appears when out_valid is high after an edge that saw ds_ready
  always @(negedge clk1) begin
    if (rst_n && out_valid && rdy_prev) begin
      if (exp_q.size() == 0) begin
        check("issue_has_expect", 32'(exp_q.size()), 32'd1);
      end else begin
        check("issue_fields", 32'({func, rd, rs1, rs2, addr}), 32'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [23:0] alu_w(input logic [1:0] f, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2,
                                        input logic [7:0] a);
    return {2'b00, f, d, s1, s2, a};
  endfunction

  task automatic expect_alu(input logic [23:0] w);
    exp_q.push_back(w[21:0]);
  endtask

  task automatic wr(input logic [4:0] a, input logic [23:0] d);
    @(posedge clk1); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk1); #1;
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk1); #1 start = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk1);
      if (halted) break;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_gap(input string tag, input int idx, input int exp);
    if (pop_cyc.size() > idx) check(tag, 32'(pop_cyc[idx] - pop_cyc[idx-1]), 32'(exp));
    else check(tag, 32'(pop_cyc.size()), 32'(idx + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk1);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bad_op", 32'(bad_op), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("rst_fields", 32'({func, rd, rs1, rs2, addr}), 32'd0);
    rst_n = 1'b1;

    // 1: two independent ALU ops then HALT
    wr(0, alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h10));
    wr(1, alu_w(2'd1, 4'd2, 4'd6, 4'd4, 8'h20));
    wr(2, W_HALT);
    expect_alu(alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h10));
    expect_alu(alu_w(2'd1, 4'd2, 4'd6, 4'd4, 8'h20));
    pulse_start();
    @(negedge clk1);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_no_issue_e0", 32'(out_valid), 32'd0);
    @(negedge clk1);
    check("s1_first_valid_e1", 32'(out_valid), 32'd1);
    @(negedge clk1);
    check("s1_halted_e2", 32'(halted), 32'd0);
    @(negedge clk1);
    check("s1_halted_e3", 32'(halted), 32'd1);
    check("s1_busy_off", 32'(busy), 32'd0);
    check("s1_issue_cnt", 32'(issue_cnt), 32'd2);
    check("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: back-to-back dependency -> 2 bubbles
    pop_cyc.delete();
    wr(0, alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h11));
    wr(1, alu_w(2'd1, 4'd2, 4'd1, 4'd4, 8'h12));
    wr(2, W_HALT);
    expect_alu(alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h11));
    expect_alu(alu_w(2'd1, 4'd2, 4'd1, 4'd4, 8'h12));
    pulse_start();
    wait_halt("s2_halt");
    check_gap("s2_gap", 1, 3);
    check("s2_bubble_cnt", 32'(bubble_cnt), 32'd2);
    check("s2_issue_cnt", 32'(issue_cnt), 32'd4);
    check("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: dependency with one gap -> 1 bubble
    pop_cyc.delete();
    wr(0, alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h21));
    wr(1, alu_w(2'd2, 4'd7, 4'd8, 4'd9, 8'h22));
    wr(2, alu_w(2'd3, 4'd3, 4'd1, 4'd2, 8'h23));
    wr(3, W_HALT);
    expect_alu(alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h21));
    expect_alu(alu_w(2'd2, 4'd7, 4'd8, 4'd9, 8'h22));
    expect_alu(alu_w(2'd3, 4'd3, 4'd1, 4'd2, 8'h23));
    pulse_start();
    wait_halt("s3_halt");
    check_gap("s3_gap1", 1, 1);
    check_gap("s3_gap2", 2, 2);
    check("s3_bubble_cnt", 32'(bubble_cnt), 32'd3);
    check("s3_issue_cnt", 32'(issue_cnt), 32'd7);

    // 4: ds_ready low for 3 cycles after the first issue; reserved op before HALT
    pop_cyc.delete();
    for (int i = 0; i < 4; i++)
      wr(5'(i), alu_w(2'(i), 4'(i + 1), 4'(8 + 2 * i), 4'(9 + 2 * i), 8'(8'h41 + i)));
    wr(4, W_RSV);
    wr(5, W_HALT);
    for (int i = 0; i < 4; i++)
      expect_alu(alu_w(2'(i), 4'(i + 1), 4'(8 + 2 * i), 4'(9 + 2 * i), 8'(8'h41 + i)));
    pulse_start();
    @(negedge clk1);
    @(posedge clk1);
    #1 ds_ready = 1'b0;
    repeat (3) begin
      @(posedge clk1);
      @(negedge clk1);
      check("s4_stall_valid", 32'(out_valid), 32'd1);
      check("s4_stall_rd", 32'(rd), 32'd1);
      check("s4_stall_issue_cnt", 32'(issue_cnt), 32'd8);
    end
    ds_ready = 1'b1;
    wait_halt("s4_halt");
    check_gap("s4_gap_stall", 1, 4);
    check_gap("s4_gap_resume", 2, 1);
    check("s4_issue_cnt", 32'(issue_cnt), 32'd11);
    check("s4_bubble_cnt", 32'(bubble_cnt), 32'd3);
    check("s4_bad_op", 32'(bad_op), 32'd1);
    check("s4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-RUN, then re-run the same memory
    wr(0, alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h10));
    wr(1, alu_w(2'd1, 4'd2, 4'd6, 4'd4, 8'h20));
    wr(2, W_HALT);
    expect_alu(alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h10));
    pulse_start();
    @(negedge clk1);
    @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_valid", 32'(out_valid), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_rd", 32'(rd), 32'd0);
    check("s5_rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("s5_rst_bad_op", 32'(bad_op), 32'd0);
    check("s5_first_popped", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk1);
    rst_n = 1'b1;
    expect_alu(alu_w(2'd0, 4'd1, 4'd5, 4'd3, 8'h10));
    expect_alu(alu_w(2'd1, 4'd2, 4'd6, 4'd4, 8'h20));
    pulse_start();
    wait_halt("s5_halt");
    check("s5_issue_cnt", 32'(issue_cnt), 32'd2);
    check("s5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: full memory of rd0 <- r15 op r15, no HALT: PC wraps, prog_we ignored in RUN
    for (int i = 0; i < 32; i++) wr(5'(i), alu_w(2'd0, 4'd0, 4'd15, 4'd15, 8'(i)));
    for (int i = 0; i < 40; i++) expect_alu(alu_w(2'd0, 4'd0, 4'd15, 4'd15, 8'(i % 32)));
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk1);
      #1;
      if (i == 5) begin
        prog_we = 1'b1; prog_addr = 5'd3; prog_data = W_HALT;
      end
      if (i == 6) prog_we = 1'b0;
      if (exp_q.size() == 0) break;
    end
    check("s6_q_empty", 32'(exp_q.size()), 32'd0);
    check("s6_issue_cnt", 32'(issue_cnt), 32'd42);
    check("s6_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("s6_not_halted", 32'(halted), 32'd0);
    check("s6_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
